rp_8bit_trace_pack: RTL

Instruction trace packer for the rp_8bit core. Sits between the core's program-memory fetch port and the testbench instruction tracer/disassembler. It watches retired fetch words and joins the two words of 32-bit instructions (lds, sts, jmp, call). It buffers complete instruction records in a small FIFO, so the consumer always receives whole instructions with their word address.

---
 rtl/rp_8bit_trace_pack.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rp_8bit_trace_pack.sv
// Instruction trace packer: joins the two words of 32-bit opcodes from the fetch stream
// and queues whole instruction records for the tracer.
module rp_8bit_trace_pack #(
  parameter int unsigned PAW   = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_vld,
  input  logic [PAW-1:0]             fetch_adr,
  input  logic [15:0]                fetch_dat,
  input  logic                       fetch_flush,
  output logic                       trc_vld,
  input  logic                       trc_rdy,
  output logic [PAW-1:0]             trc_adr,
  output logic [15:0]                trc_op0,
  output logic [15:0]                trc_op1,
  output logic                       trc_long,
  output logic [$clog2(DEPTH):0]     trc_lvl,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam logic [PAW-1:0] AdrOne = 1;

  typedef enum logic [0:0] {StIdle, StHalf} state_e;

  typedef struct packed {
    logic [PAW-1:0] adr;
    logic [15:0]    op0;
    logic [15:0]    op1;
    logic           is_long;
  } rec_t;

  // lds/sts: 1001_00x?_????_0000, jmp/call: 1001_010?_????_11??
  function automatic logic is_long_op(input logic [15:0] w);
    return ((w[15:9] == 7'b1001000 || w[15:9] == 7'b1001001) && w[3:0] == 4'b0000) ||
           (w[15:9] == 7'b1001010 && w[3:2] == 2'b11);
  endfunction

  state_e         state_q, state_d;
  logic [PAW-1:0] hold_adr_q, hold_adr_d;
  logic [15:0]    hold_word_q, hold_word_d;
  logic           half_live;
  logic           rec_push;
  rec_t           rec;
  logic           disc_drop;

  // A flush in the same cycle discards the held word before the new word is looked at.
  assign half_live = (state_q == StHalf) && !fetch_flush;

  always_comb begin
    state_d     = state_q;
    hold_adr_d  = hold_adr_q;
    hold_word_d = hold_word_q;
    rec_push    = 1'b0;
    rec         = '0;
    disc_drop   = 1'b0;
    if (fetch_flush) state_d = StIdle;
    if (fetch_vld) begin
      if (half_live && fetch_adr == hold_adr_q + AdrOne) begin
        rec_push    = 1'b1;
        rec.adr     = hold_adr_q;
        rec.op0     = hold_word_q;
        rec.op1     = fetch_dat;
        rec.is_long = 1'b1;
        state_d     = StIdle;
      end else begin
        disc_drop = half_live;
        if (is_long_op(fetch_dat)) begin
          hold_adr_d  = fetch_adr;
          hold_word_d = fetch_dat;
          state_d     = StHalf;
        end else begin
          rec_push = 1'b1;
          rec.adr  = fetch_adr;
          rec.op0  = fetch_dat;
          state_d  = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_adr_q  <= '0;
      hold_word_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_adr_q  <= hold_adr_d;
      hold_word_q <= hold_word_d;
    end
  end

  // FIFO with an extra pointer bit to tell full from empty
  rec_t        mem_q [DEPTH];
  logic [Aw:0] wptr_q, rptr_q;
  logic        empty, full, pop, push_ok, fifo_drop;
  rec_t        head;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign pop       = !empty && trc_rdy;
  assign push_ok   = rec_push && (!full || pop);
  assign fifo_drop = rec_push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[Aw-1:0]] <= rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
    end
  end

  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  logic [7:0] drop_q;

  assign drop_inc = {1'b0, disc_drop} + {1'b0, fifo_drop};
  assign drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Gate the head so outputs read zero while the FIFO is empty.
  assign head     = mem_q[rptr_q[Aw-1:0]];
  assign trc_vld  = !empty;
  assign trc_adr  = empty ? '0 : head.adr;
  assign trc_op0  = empty ? '0 : head.op0;
  assign trc_op1  = empty ? '0 : head.op1;
  assign trc_long = empty ? 1'b0 : head.is_long;
  assign trc_lvl  = wptr_q - rptr_q;
  assign drop_cnt = drop_q;

endmodule
